bus_host_arbiter: RTL and testbench

BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

---
 rtl/bus_host_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bus_host_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - two-host arbiter onto a single Avalon-style bus with in-order response routing
//
// Purpose: selects one of two hosts (0 = core data port, 1 = debug SBA master)
// per cycle and drives its command onto the bus. It holds a stalled command
// until the bus accepts it. It tracks granted transactions in an in-order ID
// FIFO and routes each bus response to the host at the FIFO head.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   hN_req_i/we_i/be_i/addr_i/wdata_i   host N command (N = 0,1)
//   hN_gnt_o                     host N command accepted this cycle
//   hN_rvalid_o/rdata_o/err_o    host N response
//   bus_read_o/write_o/addr_o/be_o/wdata_o   bus command
//   bus_busy_i                   bus waitrequest
//   bus_rvalid_i/wrespvalid_i/rdata_i/resp_i bus response
//   protocol_err_o               sticky: response arrived with nothing outstanding
module bus_host_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter bit Host1Priority  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        h0_req_i,
  input  logic        h0_we_i,
  input  logic [3:0]  h0_be_i,
  input  logic [31:0] h0_addr_i,
  input  logic [31:0] h0_wdata_i,
  output logic        h0_gnt_o,
  output logic        h0_rvalid_o,
  output logic [31:0] h0_rdata_o,
  output logic        h0_err_o,
  input  logic        h1_req_i,
  input  logic        h1_we_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h1_addr_i,
  input  logic [31:0] h1_wdata_i,
  output logic        h1_gnt_o,
  output logic        h1_rvalid_o,
  output logic [31:0] h1_rdata_o,
  output logic        h1_err_o,
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_busy_i,
  input  logic        bus_rvalid_i,
  input  logic        bus_wrespvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic [1:0]  bus_resp_i,
  output logic        protocol_err_o
);

  localparam logic [3:0] max_count = 4'(MaxOutstanding);
  localparam logic [2:0] last_ptr  = 3'(MaxOutstanding - 1);

  // Stalled-command lock: selection and fields captured while the bus is busy
  logic        locked;
  logic        lock_host;
  logic        lock_we;
  logic [3:0]  lock_be;
  logic [31:0] lock_addr;
  logic [31:0] lock_wdata;

  logic        last_host;
  logic [7:0]  ids;
  logic [2:0]  rd_ptr;
  logic [2:0]  wr_ptr;
  logic [3:0]  count;
  logic        perr;

  logic        sel_valid;
  logic        sel_host;
  logic        resp_any;
  logic        pop;
  logic        room;
  logic        cmd_valid;
  logic        grant;
  logic        head_host;
  logic        cmd_we;

  function automatic logic [2:0] next_ptr(input logic [2:0] ptr);
    return (ptr == last_ptr) ? 3'd0 : ptr + 3'd1;
  endfunction

  always_comb begin
    sel_valid = locked | h0_req_i | h1_req_i;
    if (locked)
      sel_host = lock_host;
    else if (h0_req_i && h1_req_i)
      sel_host = Host1Priority ? 1'b1 : ~last_host;
    else
      sel_host = h1_req_i;

    resp_any  = bus_rvalid_i | bus_wrespvalid_i;
    pop       = resp_any && (count != 4'd0) && !rst_i;
    // A full FIFO still accepts a grant when the head retires this same cycle
    room      = (count < max_count) || pop;
    cmd_valid = sel_valid && room && !rst_i;
    grant     = cmd_valid && !bus_busy_i;

    if (locked) begin
      cmd_we      = lock_we;
      bus_addr_o  = lock_addr;
      bus_be_o    = lock_be;
      bus_wdata_o = lock_wdata;
    end else if (sel_host) begin
      cmd_we      = h1_we_i;
      bus_addr_o  = h1_addr_i;
      bus_be_o    = h1_be_i;
      bus_wdata_o = h1_wdata_i;
    end else begin
      cmd_we      = h0_we_i;
      bus_addr_o  = h0_addr_i;
      bus_be_o    = h0_be_i;
      bus_wdata_o = h0_wdata_i;
    end
    bus_read_o  = cmd_valid & ~cmd_we;
    bus_write_o = cmd_valid & cmd_we;

    h0_gnt_o    = grant & ~sel_host;
    h1_gnt_o    = grant & sel_host;

    head_host   = ids[rd_ptr];
    h0_rvalid_o = pop & ~head_host;
    h1_rvalid_o = pop & head_host;
    h0_err_o    = h0_rvalid_o & (bus_resp_i != 2'b00);
    h1_err_o    = h1_rvalid_o & (bus_resp_i != 2'b00);
    h0_rdata_o  = bus_rdata_i;
    h1_rdata_o  = bus_rdata_i;

    protocol_err_o = perr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked     <= 1'b0;
      lock_host  <= 1'b0;
      lock_we    <= 1'b0;
      lock_be    <= 4'd0;
      lock_addr  <= 32'd0;
      lock_wdata <= 32'd0;
      last_host  <= 1'b1;
      rd_ptr     <= 3'd0;
      wr_ptr     <= 3'd0;
      count      <= 4'd0;
      perr       <= 1'b0;
    end else begin
      if (grant) begin
        locked <= 1'b0;
      end else if (cmd_valid && bus_busy_i) begin
        locked     <= 1'b1;
        lock_host  <= sel_host;
        lock_we    <= cmd_we;
        lock_be    <= bus_be_o;
        lock_addr  <= bus_addr_o;
        lock_wdata <= bus_wdata_o;
      end

      if (grant) begin
        wr_ptr    <= next_ptr(wr_ptr);
        last_host <= sel_host;
      end
      if (pop)
        rd_ptr <= next_ptr(rd_ptr);

      if (grant && !pop)
        count <= count + 4'd1;
      else if (pop && !grant)
        count <= count - 4'd1;

      if (resp_any && (count == 4'd0))
        perr <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk_i) begin
    if (grant)
      ids[wr_ptr] <= sel_host;
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb/tb_bus_host_arbiter.sv - scoreboard bench for bus_host_arbiter
module tb_bus_host_arbiter;

  localparam int MAX = 2;
  localparam bit H1P = 1'b0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        h0_req_i = 1'b0, h0_we_i = 1'b0;
  logic [3:0]  h0_be_i = 4'd0;
  logic [31:0] h0_addr_i = 32'd0, h0_wdata_i = 32'd0;
  logic        h1_req_i = 1'b0, h1_we_i = 1'b0;
  logic [3:0]  h1_be_i = 4'd0;
  logic [31:0] h1_addr_i = 32'd0, h1_wdata_i = 32'd0;
  logic        h0_gnt_o, h0_rvalid_o, h0_err_o;
  logic [31:0] h0_rdata_o;
  logic        h1_gnt_o, h1_rvalid_o, h1_err_o;
  logic [31:0] h1_rdata_o;
  logic        bus_read_o, bus_write_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_busy_i = 1'b0, bus_rvalid_i = 1'b0, bus_wrespvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
  logic [1:0]  bus_resp_i = 2'd0;
  logic        protocol_err_o;

  bus_host_arbiter #(.MaxOutstanding(MAX), .Host1Priority(H1P)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .h0_req_i(h0_req_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i),
    .h0_addr_i(h0_addr_i), .h0_wdata_i(h0_wdata_i),
    .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o), .h0_err_o(h0_err_o),
    .h1_req_i(h1_req_i), .h1_we_i(h1_we_i), .h1_be_i(h1_be_i),
    .h1_addr_i(h1_addr_i), .h1_wdata_i(h1_wdata_i),
    .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o), .h1_err_o(h1_err_o),
    .bus_read_o(bus_read_o), .bus_write_o(bus_write_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_busy_i(bus_busy_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_wrespvalid_i(bus_wrespvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_resp_i(bus_resp_i), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic host; logic [31:0] addr; logic we; } grant_t;
  typedef struct packed { logic host; logic [31:0] data; logic err; } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: outstanding host IDs in grant order, plus arbitration memory
  bit          mq[$];
  bit          m_last = 1'b1;
  bit          m_locked = 1'b0;
  bit          m_lock_host = 1'b0;
  logic [31:0] m_lock_addr = 32'd0;
  bit          m_lock_we = 1'b0;
  bit          m_perr = 1'b0;

  // Pending transaction per host
  logic        p_we[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];
  logic [3:0]  p_be[2];

  // Observations of the last cycle, for directed checks
  logic [31:0] obs_addr;
  logic        obs_g0, obs_g1, obs_r0, obs_r1, obs_e1;
  bit          g_valid;
  bit          g_host;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic new_txn(input int h, input logic we, input logic [31:0] addr);
    p_we[h]    = we;
    p_addr[h]  = addr;
    p_wdata[h] = $urandom;
    p_be[h]    = 4'($urandom_range(1, 15));
  endtask

  task automatic do_reset();
    #1;
    rst_i = 1'b1; h0_req_i = 1'b1; h1_req_i = 1'b1;
    bus_rvalid_i = 1'b0; bus_wrespvalid_i = 1'b0; bus_busy_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    mq.delete();
    m_last = 1'b1; m_locked = 1'b0; m_perr = 1'b0;
  endtask

  // One clock cycle: drive, predict, sample, advance the model
  task automatic cycle(input bit r0, input bit r1, input bit busy, input bit rsp, input logic [1:0] code);
    bit pop, room, cmd, grant, sel, kind;
    logic [31:0] data;
    grant_t g;
    resp_t r;
    #1;
    rst_i = 1'b0;
    h0_req_i = r0; h0_we_i = p_we[0]; h0_addr_i = p_addr[0]; h0_wdata_i = p_wdata[0]; h0_be_i = p_be[0];
    h1_req_i = r1; h1_we_i = p_we[1]; h1_addr_i = p_addr[1]; h1_wdata_i = p_wdata[1]; h1_be_i = p_be[1];
    bus_busy_i = busy;
    data = $urandom;
    kind = 1'($urandom_range(0, 1));
    bus_rdata_i = data;
    bus_resp_i = rsp ? code : 2'b00;
    bus_rvalid_i = rsp & kind;
    bus_wrespvalid_i = rsp & ~kind;

    pop  = rsp && (mq.size() > 0);
    room = (mq.size() < MAX) || pop;
    if (m_locked) sel = m_lock_host;
    else if (r0 && r1) sel = H1P ? 1'b1 : ~m_last;
    else sel = r1;
    cmd   = (m_locked || r0 || r1) && room;
    grant = cmd && !busy;
    if (grant) begin
      g.host = sel;
      g.addr = m_locked ? m_lock_addr : p_addr[sel];
      g.we   = m_locked ? m_lock_we : p_we[sel];
      gq.push_back(g);
    end
    if (pop) begin
      r.host = mq[0];
      r.data = data;
      r.err  = (code != 2'b00);
      rq.push_back(r);
    end

    #2;
    check("protocol_err", {31'd0, protocol_err_o}, {31'd0, m_perr});
    if (mq.size() == MAX && !pop)
      check("full_no_cmd", {30'd0, bus_read_o, bus_write_o}, 32'd0);
    obs_addr = bus_addr_o;
    obs_g0 = h0_gnt_o; obs_g1 = h1_gnt_o;
    obs_r0 = h0_rvalid_o; obs_r1 = h1_rvalid_o; obs_e1 = h1_err_o;

    if (rsp && mq.size() == 0) m_perr = 1'b1;
    if (pop) void'(mq.pop_front());
    g_valid = grant;
    g_host  = sel;
    if (grant) begin
      mq.push_back(sel);
      m_last = sel;
      m_locked = 1'b0;
    end else if (cmd && busy) begin
      m_locked = 1'b1;
      m_lock_host = sel;
      m_lock_addr = m_locked && m_lock_host == sel ? (m_lock_addr) : p_addr[sel];
      m_lock_addr = p_addr[sel];
      m_lock_we = p_we[sel];
    end
    @(posedge clk_i);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a response
  always @(negedge clk_i) begin
    if (rst_i) begin
      checks++;
      if (h0_gnt_o | h1_gnt_o | h0_rvalid_o | h1_rvalid_o | bus_read_o | bus_write_o) begin
        errors++;
        $display("FAIL reset_outputs actual=%b required=000000",
                 {h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o, bus_read_o, bus_write_o});
      end
    end else begin
      if (h0_gnt_o | h1_gnt_o) begin
        grant_t g;
        checks++;
        if (h0_gnt_o & h1_gnt_o) begin
          errors++;
          $display("FAIL grant_onehot actual=11 required=one grant");
        end else if (gq.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected actual=h%0d required=none", h1_gnt_o);
        end else begin
          g = gq.pop_front();
          if (h1_gnt_o !== g.host || bus_addr_o !== g.addr || bus_write_o !== g.we) begin
            errors++;
            $display("FAIL grant actual=h%0d addr=%h we=%b required=h%0d addr=%h we=%b",
                     h1_gnt_o, bus_addr_o, bus_write_o, g.host, g.addr, g.we);
          end
        end
      end else if (gq.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL grant_missing actual=none required=h%0d", gq[0].host);
        void'(gq.pop_front());
      end

      if (h0_rvalid_o | h1_rvalid_o) begin
        resp_t r;
        logic [31:0] d;
        logic e;
        checks++;
        d = h1_rvalid_o ? h1_rdata_o : h0_rdata_o;
        e = h1_rvalid_o ? h1_err_o : h0_err_o;
        if (h0_rvalid_o & h1_rvalid_o) begin
          errors++;
          $display("FAIL rvalid_onehot actual=11 required=one rvalid");
        end else if (rq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected actual=h%0d required=none", h1_rvalid_o);
        end else begin
          r = rq.pop_front();
          if (h1_rvalid_o !== r.host || d !== r.data || e !== r.err ||
              (h1_rvalid_o ? h0_err_o : h1_err_o) !== 1'b0) begin
            errors++;
            $display("FAIL resp actual=h%0d data=%h err=%b required=h%0d data=%h err=%b",
                     h1_rvalid_o, d, e, r.host, r.data, r.err);
          end
        end
      end else if (rq.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL resp_missing actual=none required=h%0d", rq[0].host);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    bit act[2];
    new_txn(0, 1'b0, 32'h0000_1000);
    new_txn(1, 1'b0, 32'h0000_2000);
    @(posedge clk_i);
    do_reset();

    // Both hosts read continuously, a response every cycle after a grant: alternate h0,h1
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, mq.size() > 0, 2'b00);
      check("rr_alternate", {31'd0, obs_g0}, {31'd0, (i % 2) == 0});
      new_txn(i % 2, 1'b0, 32'h0000_3000 + 32'(i * 4));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);

    // Stalled write held on the bus for 4 cycles, then h1 follows
    do_reset();
    new_txn(0, 1'b1, 32'h0000_0100);
    new_txn(1, 1'b0, 32'h0000_0200);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, i < 3, 1'b0, 2'b00);
      check("lock_addr", obs_addr, 32'h0000_0100);
      check("lock_gnt", {31'd0, obs_g0}, {31'd0, i == 3});
    end
    new_txn(0, 1'b0, 32'h0000_0300);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("h1_after_lock", {31'd0, obs_g1}, 32'd1);

    // FIFO full: no grant until a response pops, then exactly one grant that cycle
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("full_no_gnt", {31'd0, obs_g0}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    check("gnt_on_pop", {31'd0, obs_g0}, 32'd1);
    new_txn(0, 1'b0, 32'h0000_0400);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("full_again", {31'd0, obs_g0}, 32'd0);

    // Error response routed to h1 only
    do_reset();
    new_txn(1, 1'b0, 32'h0000_0500);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    check("err_h1_rvalid", {30'd0, obs_r1, obs_e1}, 32'd3);
    check("err_h0_rvalid", {31'd0, obs_r0}, 32'd0);

    // Spurious response: no rvalid, sticky protocol error until reset
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("spurious_rvalid", {30'd0, obs_r0, obs_r1}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset with two outstanding transactions discards them
    do_reset();
    new_txn(0, 1'b0, 32'h0000_0600);
    new_txn(1, 1'b0, 32'h0000_0700);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("post_reset_spurious", {30'd0, obs_r0, obs_r1}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    check("post_reset_first_h0", {31'd0, obs_g0}, 32'd1);

    // Randomized traffic against the model
    do_reset();
    act[0] = 1'b0;
    act[1] = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bit busy, rsp;
      logic [1:0] code;
      for (int h = 0; h < 2; h++)
        if (!act[h] && $urandom_range(0, 2) == 0) begin
          new_txn(h, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
          act[h] = 1'b1;
        end
      busy = ($urandom_range(0, 3) == 0);
      rsp  = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(act[0], act[1], busy, rsp, code);
      if (g_valid) act[g_host] = 1'b0;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk_i);
    check("scoreboard_drained", gq.size() + rq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
